flag_event_queue: RTL and testbench
===================================

# flag_event_queue

Single-clock source-side front end for a toggle-based flag clock-domain crossing. Accepts single-cycle event strobes from local logic, counts those not yet sent, and issues them one at a time as one-cycle flags toward the crossing while honouring its `busy` return. No event is lost while the crossing is occupied, up to counter capacity. Sits in the source clock domain, directly ahead of the crossing's `flag_in`/`busy` pair.

## Interface
Parameters:
- `COUNT_WIDTH`, 8: width of pending-event counter; capacity 2^COUNT_WIDTH−1 events.
- `ACCEPT_TIMEOUT`, 4: cycles in WAIT_ACCEPT without `busy_in` before retry (only with timeout feature); legal range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  source-domain clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `event_in`  in  1  each high cycle = one event.
- `busy_in`  in  1  crossing busy: high while a flag is in flight.
- `flag_out`  out  1  one-cycle flag to crossing `flag_in`; registered.
- `pending`  out  COUNT_WIDTH  events accepted but not yet acknowledged.
- `overflow`  out  1  sticky; an event was dropped at saturation.
- `overflow_clear`  in  1  clears `overflow`.
- `drained`  out  1  high when `pending`==0 and state is IDLE.

## Operation
- Reset values: state IDLE, `pending`=0, `flag_out`=0, `overflow`=0, `drained`=1, timeout counter 0.
- States:
  - IDLE: go to ISSUE when `pending`≠0 and `busy_in`=0; otherwise stay.
  - ISSUE: `flag_out`=1 for this one cycle only; go unconditionally to WAIT_ACCEPT.
  - WAIT_ACCEPT: if `busy_in`=1, decrement `pending` and go to WAIT_FREE.
  - WAIT_FREE: stay while `busy_in`=1; go to IDLE on `busy_in`=0.
- `flag_out` = (state==ISSUE); never high in two consecutive cycles.
- Counter update per cycle: +1 if `event_in`; −1 if accept (WAIT_ACCEPT with `busy_in`=1).
  - Both in the same cycle: net unchanged.
  - +1 alone at all-ones: `pending` holds and `overflow` sets.
  - A decrement never occurs at 0; this is guaranteed by construction.
- `overflow`: set has priority over `overflow_clear` when both occur in the same cycle.
- Reset mid-operation (any state): everything returns to reset values next cycle; pending events are discarded.

## Timing
- `event_in` at edge N: `pending` increments at N+1.
- From idle with `busy_in`=0: event at edge N → state ISSUE at N+2 → `flag_out` high during the cycle after edge N+2.
- The crossing raises `busy_in` one cycle after the ISSUE cycle. The accept is therefore normally seen in the first WAIT_ACCEPT cycle, and `pending` decrements on the following edge.
- Back-to-back flags are separated by at least the crossing's busy round-trip plus 2 cycles (WAIT_FREE→IDLE→ISSUE).
- `drained` is combinational from registered state and `pending`.

## Configuration
- `FLAG_EVENT_QUEUE_TIMEOUT_EN` defined:
  - WAIT_ACCEPT counts cycles with `busy_in`=0.
  - After `ACCEPT_TIMEOUT` such cycles, return to IDLE without decrementing, so the event is reissued.
  - The counter clears on leaving WAIT_ACCEPT.
- Macro undefined: WAIT_ACCEPT waits indefinitely for `busy_in`; no timeout counter is built.

## Test plan
- Single event: `event_in` 1 cycle, crossing attached, idle → exactly one `flag_out` pulse; `pending` goes 0→1→0; `drained` returns to 1.
- Burst: `event_in` high 3 consecutive cycles → `pending` peaks at 3; exactly 3 `flag_out` pulses, each after `busy_in` falls; final `pending`=0, `overflow`=0.
- Saturation (COUNT_WIDTH=2, `busy_in` held 1): 5 events → `pending`=3 and `overflow`=1. Assert `overflow_clear` together with a 6th event → `overflow` stays 1. Clear alone → `overflow`=0.
- Simultaneous: `event_in` in the accept cycle with `pending`=1 → `pending` stays 1; a second flag follows.
- Timeout (macro defined, ACCEPT_TIMEOUT=4, `busy_in` forced 0): one event → `flag_out` pulse, 4 WAIT_ACCEPT cycles, back to IDLE with `pending`=1, then a second `flag_out` pulse. Macro undefined → only one pulse, state stays WAIT_ACCEPT.
- Reset mid-operation: `reset` in WAIT_FREE with `pending`=2 → next cycle `pending`=0, `flag_out`=0, `overflow`=0, `drained`=1, no further flags.

Source files
------------

// File: rtl/flag_event_queue.sv
// flag_event_queue: source-side front end for a toggle-based flag crossing.
// Counts local event strobes and issues them one at a time as single-cycle
// flags, waiting for the crossing's busy handshake between flags.
// Optional feature macro: FLAG_EVENT_QUEUE_TIMEOUT_EN (re-issue a flag when
// busy_in never rises within ACCEPT_TIMEOUT cycles).
module flag_event_queue #(
  parameter int unsigned COUNT_WIDTH    = 8,
  parameter int unsigned ACCEPT_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   event_in,
  input  logic                   busy_in,
  output logic                   flag_out,
  output logic [COUNT_WIDTH-1:0] pending,
  output logic                   overflow,
  input  logic                   overflow_clear,
  output logic                   drained
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ISSUE       = 2'd1,
    S_WAIT_ACCEPT = 2'd2,
    S_WAIT_FREE   = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] PEND_ONE = COUNT_WIDTH'(1);

  // Reject a timeout value the 8-bit timeout counter cannot represent.
  if (ACCEPT_TIMEOUT < 1 || ACCEPT_TIMEOUT > 255) begin : g_param_check
    $error("flag_event_queue: ACCEPT_TIMEOUT must be within 1..255");
  end

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   pend_q, pend_d;
  logic                     ovf_q, ovf_d;
  logic                     flag_q, flag_d;
  logic                     accept_c;
  logic                     sat_c;

`ifdef FLAG_EVENT_QUEUE_TIMEOUT_EN
  localparam int unsigned   TMO_W    = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACCEPT_TIMEOUT - 1);
  logic [TMO_W-1:0]         tmo_q, tmo_d;
`endif

  // Handshake sequencing: issue one flag, wait for busy to rise, then fall.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
`ifdef FLAG_EVENT_QUEUE_TIMEOUT_EN
    tmo_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pend_q != '0 && !busy_in) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        if (busy_in) begin
          accept_c = 1'b1;
          state_d  = S_WAIT_FREE;
        end
`ifdef FLAG_EVENT_QUEUE_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      S_WAIT_FREE: begin
        if (!busy_in) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    flag_d = (state_d == S_ISSUE);
  end

  // Pending counter and sticky overflow; a simultaneous event and accept cancel.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    sat_c  = event_in && !accept_c && (pend_q == PEND_MAX);
    if (event_in && !accept_c && !sat_c) begin
      pend_d = pend_q + PEND_ONE;
    end else if (accept_c && !event_in) begin
      pend_d = pend_q - PEND_ONE;
    end
    if (sat_c) begin
      ovf_d = 1'b1;
    end else if (overflow_clear) begin
      ovf_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      flag_q  <= 1'b0;
`ifdef FLAG_EVENT_QUEUE_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      flag_q  <= flag_d;
`ifdef FLAG_EVENT_QUEUE_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign flag_out = flag_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;
  assign drained  = (pend_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_flag_event_queue.sv
// Testbench for flag_event_queue: randomized events against a crossing model,
// with a per-cycle scoreboard fed by a behavioural reference model.
module tb_flag_event_queue;

  localparam int unsigned CW   = 2;
  localparam int unsigned TMO  = 4;
  localparam int          PMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          event_in = 1'b0;
  logic          busy_in = 1'b0;
  logic          overflow_clear = 1'b0;
  logic          flag_out;
  logic          overflow;
  logic          drained;
  logic [CW-1:0] pending;

  always #5 clk = ~clk;

  flag_event_queue #(
    .COUNT_WIDTH   (CW),
    .ACCEPT_TIMEOUT(TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .event_in      (event_in),
    .busy_in       (busy_in),
    .flag_out      (flag_out),
    .pending       (pending),
    .overflow      (overflow),
    .overflow_clear(overflow_clear),
    .drained       (drained)
  );

  typedef struct packed {
    logic [CW-1:0] pend;
    logic          ovf;
    logic          flag;
    logic          drn;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   flags_seen = 0;

  // Reference model: event count with saturation plus handshake progress.
  int   m_pend = 0;
  bit   m_ovf = 0;
  bit   m_flag = 0;     // a flag is expected in the coming cycle
  bit   m_await = 0;    // flag sent, busy not yet seen
  bit   m_drain = 0;    // busy seen, waiting for it to fall
  int   m_wait_cnt = 0;
  int   m_accepted = 0;

  // Crossing environment: 0 normal, 1 busy forced high, 2 busy forced low.
  int   busy_mode = 0;
  int   busy_left = 0;
  bit   ev_on_accept = 0;
  bit   sim_hit = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic bit m_free();
    return !m_flag && !m_await && !m_drain;
  endfunction

  function automatic void model_step(input bit e, input bit clr, input bit rst, input bit b);
    bit acc, sat, nflag;
    if (rst) begin
      m_pend = 0; m_ovf = 0; m_flag = 0; m_await = 0; m_drain = 0; m_wait_cnt = 0;
    end else begin
      acc   = m_await && b;
      nflag = m_free() && (m_pend > 0) && !b;
      sat   = e && !acc && (m_pend == PMAX);
      if (m_flag) begin
        m_await = 1;
      end else if (m_await) begin
        if (b) begin
          m_await = 0; m_drain = 1; m_wait_cnt = 0;
        end
`ifdef FLAG_EVENT_QUEUE_TIMEOUT_EN
        else begin
          m_wait_cnt++;
          if (m_wait_cnt == TMO) begin
            m_await = 0; m_wait_cnt = 0;
          end
        end
`endif
      end else if (m_drain && !b) begin
        m_drain = 0;
      end
      if (e && !acc && !sat) begin
        m_pend++; m_accepted++;
      end else if (acc && !e) begin
        m_pend--;
      end
      if (e && acc) m_accepted++;
      m_ovf  = sat ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_flag = nflag;
    end
  endfunction

  // One cycle: publish expectations, run the crossing, drive inputs, advance model.
  task automatic cyc(input bit e, input bit clr, input bit rst);
    exp_t x;
    bit   b;
    bit   e2;
    @(posedge clk);
    #1;
    x.pend = CW'(m_pend);
    x.ovf  = m_ovf;
    x.flag = m_flag;
    x.drn  = (m_pend == 0) && m_free();
    exp_q.push_back(x);
    if (busy_mode == 1)      b = 1'b1;
    else if (busy_mode == 2) b = 1'b0;
    else                     b = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    if (flag_out === 1'b1 && busy_mode == 0) busy_left = $urandom_range(1, 4);
    e2 = e;
    if (ev_on_accept && m_await && b) begin
      e2 = 1'b1; ev_on_accept = 0; sim_hit = 1;
    end
    event_in       = e2;
    overflow_clear = clr;
    reset          = rst;
    busy_in        = b;
    model_step(e2, clr, rst, b);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!(m_pend == 0 && m_free() && busy_left == 0) && n < 60) begin
      cyc(0, 0, 0);
      n++;
    end
    repeat (3) cyc(0, 0, 0);
    chk({name, "_drained"}, 32'(drained), 32'd1);
    chk({name, "_pending_zero"}, 32'(pending), 32'd0);
  endtask

  // Scoreboard monitor: compare every published cycle away from the active edge.
  always @(negedge clk) begin
    exp_t x;
    if (flag_out === 1'b1) flags_seen++;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      chk("sb_pending",  32'(pending),  32'(x.pend));
      chk("sb_overflow", 32'(overflow), 32'(x.ovf));
      chk("sb_flag",     32'(flag_out), 32'(x.flag));
      chk("sb_drained",  32'(drained),  32'(x.drn));
    end
  end

  initial begin
    int f0;
    int a0;
    int n;

    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("reset_pending",  32'(pending),  32'd0);
    chk("reset_flag",     32'(flag_out), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_drained",  32'(drained),  32'd1);

    // Single event
    f0 = flags_seen;
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("single_pending_one", 32'(pending), 32'd1);
    drain("single");
    chk("single_flag_count", 32'(flags_seen - f0), 32'd1);

    // Burst of three
    f0 = flags_seen;
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("burst_peak", 32'(pending), 32'd3);
    drain("burst");
    chk("burst_flag_count", 32'(flags_seen - f0), 32'd3);
    chk("burst_overflow", 32'(overflow), 32'd0);

    // Saturation with busy held high
    f0 = flags_seen;
    busy_mode = 1;
    repeat (5) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("sat_pending", 32'(pending), 32'd3);
    chk("sat_overflow", 32'(overflow), 32'd1);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("sat_set_beats_clear", 32'(overflow), 32'd1);
    chk("sat_pending_hold", 32'(pending), 32'd3);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("sat_clear", 32'(overflow), 32'd0);
    busy_mode = 0;
    drain("sat");
    chk("sat_flag_count", 32'(flags_seen - f0), 32'd3);

    // Event in the accept cycle
    f0 = flags_seen;
    sim_hit = 0;
    cyc(1, 0, 0);
    ev_on_accept = 1;
    n = 0;
    while (!sim_hit && n < 20) begin
      cyc(0, 0, 0);
      n++;
    end
    ev_on_accept = 0;
    chk("simul_accept_seen", 32'(sim_hit), 32'd1);
    cyc(0, 0, 0);
    chk("simul_pending_hold", 32'(pending), 32'd1);
    drain("simul");
    chk("simul_flag_count", 32'(flags_seen - f0), 32'd2);

    // Crossing never answers
    f0 = flags_seen;
    busy_mode = 2;
    cyc(1, 0, 0);
    repeat (14) cyc(0, 0, 0);
`ifdef FLAG_EVENT_QUEUE_TIMEOUT_EN
    chk("timeout_reissue", 32'((flags_seen - f0) >= 2), 32'd1);
`else
    chk("no_timeout_single_flag", 32'(flags_seen - f0), 32'd1);
`endif
    chk("no_answer_pending", 32'(pending), 32'd1);
    busy_mode = 0;
    busy_left = 2;
    drain("no_answer");

    // Randomized traffic
    f0 = flags_seen;
    a0 = m_accepted;
    repeat (1500) cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), 0);
    drain("random");
    chk("random_flag_count", 32'(flags_seen - f0), 32'(m_accepted - a0));

    // Reset while waiting for busy to fall with two events still pending
    repeat (3) cyc(1, 0, 0);
    n = 0;
    while (!(m_drain && m_pend == 2) && n < 20) begin
      cyc(0, 0, 0);
      n++;
    end
    chk("rst_reached_wait_free", 32'(m_drain && m_pend == 2), 32'd1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("rst_pending",  32'(pending),  32'd0);
    chk("rst_flag",     32'(flag_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drained",  32'(drained),  32'd1);
    f0 = flags_seen;
    repeat (10) cyc(0, 0, 0);
    chk("rst_no_more_flags", 32'(flags_seen - f0), 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
